// File: rtl/vc_arbiter_ctrl.sv
// Scheduler moving words from two virtual-channel FIFOs into two
// destination FIFOs, with VC0 priority bounded by VC1 anti-starvation.
module vc_arbiter_ctrl #(
  parameter int DATA_WIDTH   = 6,
  parameter int DEST_BIT     = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  output logic                  vc0_pop,
  output logic                  vc1_pop,
  input  logic                  d0_almost_full,
  input  logic                  d1_almost_full,
  output logic                  d0_push,
  output logic                  d1_push,
  output logic [DATA_WIDTH-1:0] d_data,
  output logic                  pause,
  output logic [CNT_WIDTH-1:0]  d0_count,
  output logic [CNT_WIDTH-1:0]  d1_count
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {OFF, RUN, PAUSE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SW-1:0]   starve_cnt;
  logic [SW-1:0]   starve_nxt;
  logic            grant0;
  logic            grant1;
  logic            can_pop;
  logic            af;
  logic            vld;
  logic            sel1;
  logic [DATA_WIDTH-1:0] word;

  assign af    = d0_almost_full | d1_almost_full;
  assign word  = sel1 ? vc1_data : vc0_data;
  assign pause = (state == PAUSE);

  always_comb begin
    state_nxt  = state;
    can_pop    = 1'b0;
    grant0     = 1'b0;
    grant1     = 1'b0;
    starve_nxt = starve_cnt;
    unique case (state)
      OFF: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (!enable)  state_nxt = OFF;
        else if (af)  state_nxt = PAUSE;
        else          can_pop   = 1'b1;
      end
      PAUSE: begin
        if (!enable) begin
          state_nxt = OFF;
        end else if (!af) begin
          state_nxt = RUN;
          can_pop   = 1'b1;
        end
      end
      default: state_nxt = OFF;
    endcase
    // VC1 wins a contested slot only once the limit is reached
    if (can_pop) begin
      if (!vc0_empty && (vc1_empty || starve_cnt != LIMIT))
        grant0 = 1'b1;
      else if (!vc1_empty)
        grant1 = 1'b1;
    end
    if (vc1_empty || grant1)
      starve_nxt = '0;
    else if (grant0 && starve_cnt != LIMIT)
      starve_nxt = starve_cnt + SW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= OFF;
      starve_cnt <= '0;
      vc0_pop    <= 1'b0;
      vc1_pop    <= 1'b0;
      vld        <= 1'b0;
      sel1       <= 1'b0;
      d0_push    <= 1'b0;
      d1_push    <= 1'b0;
      d_data     <= '0;
      d0_count   <= '0;
      d1_count   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      vc0_pop    <= grant0;
      vc1_pop    <= grant1;
      vld        <= vc0_pop | vc1_pop;
      sel1       <= vc1_pop;
      d0_push    <= vld & ~word[DEST_BIT];
      d1_push    <= vld &  word[DEST_BIT];
      if (vld) begin
        d_data <= word;
        if (word[DEST_BIT]) d1_count <= d1_count + CNT_WIDTH'(1);
        else                d0_count <= d0_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_vc_arbiter_ctrl.sv
// Directed bench for vc_arbiter_ctrl: behavioural VC FIFOs feed the
// DUT and a scoreboard checks order, routing and latency of pushes.
module tb_vc_arbiter_ctrl;

  localparam int DW = 6;
  localparam int DB = 4;
  localparam int SL = 4;
  localparam int CW = 8;

  typedef struct packed {
    logic          dest;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          vc0_empty = 1'b1;
  logic          vc1_empty = 1'b1;
  logic [DW-1:0] vc0_data = '0;
  logic [DW-1:0] vc1_data = '0;
  logic          vc0_pop;
  logic          vc1_pop;
  logic          d0_almost_full = 1'b0;
  logic          d1_almost_full = 1'b0;
  logic          d0_push;
  logic          d1_push;
  logic [DW-1:0] d_data;
  logic          pause;
  logic [CW-1:0] d0_count;
  logic [CW-1:0] d1_count;

  vc_arbiter_ctrl #(
    .DATA_WIDTH(DW), .DEST_BIT(DB),
    .STARVE_LIMIT(SL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
    .d0_almost_full(d0_almost_full),
    .d1_almost_full(d1_almost_full),
    .d0_push(d0_push), .d1_push(d1_push),
    .d_data(d_data), .pause(pause),
    .d0_count(d0_count), .d1_count(d1_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_pop0 = 0;
  int n_push = 0;
  int exp_d0 = 0;
  int exp_d1 = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] pend0 = '0;
  logic [DW-1:0] pend1 = '0;
  exp_t          sb[$];
  int            lat_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // VC FIFO model: the pop is taken on the edge that raises the strobe,
  // and the word appears on the data bus one cycle later.
  always @(posedge clk) begin
    cyc++;
    #1;
    vc0_data = pend0;
    vc1_data = pend1;
    if (vc0_pop) begin
      chk("pop0_nonempty", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) pend0 = q0.pop_front();
      lat_q.push_back(cyc);
      n_pop0++;
    end
    if (vc1_pop) begin
      chk("pop1_nonempty", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) pend1 = q1.pop_front();
      lat_q.push_back(cyc);
    end
    if (!reset) chk("pop_excl", 32'(vc0_pop & vc1_pop), 32'd0);
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
  end

  always @(negedge clk) begin
    exp_t e;
    int   lp;
    if (d0_push || d1_push) begin
      n_push++;
      chk("push_excl", 32'(d0_push & d1_push), 32'd0);
      if (sb.size() == 0) begin
        chk("push_unexpected", {30'd0, d1_push, d0_push}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("push_data", 32'(d_data), 32'(e.data));
        chk("push_dest", {30'd0, d1_push, d0_push},
            e.dest ? 32'd2 : 32'd1);
        if (e.dest) exp_d1++;
        else        exp_d0++;
      end
      if (lat_q.size() != 0) begin
        lp = lat_q.pop_front();
        chk("latency", 32'(cyc), 32'(lp + 2));
      end
    end
  end

  task automatic load(input bit vc, input logic [DW-1:0] w);
    if (vc) begin q1.push_back(w); vc1_empty = 1'b0; end
    else    begin q0.push_back(w); vc0_empty = 1'b0; end
  endtask

  task automatic expect_w(input logic [DW-1:0] w);
    exp_t e;
    e.dest = w[DB];
    e.data = w;
    sb.push_back(e);
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete(); sb.delete(); lat_q.delete();
    vc0_empty = 1'b1;
    vc1_empty = 1'b1;
    exp_d0 = 0;
    exp_d1 = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((sb.size() != 0 || lat_q.size() != 0) && n < max) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_pop0(input int target, input int max);
    int n = 0;
    while (n_pop0 < target && n < max) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("pop_timeout", 32'(n_pop0), 32'(target));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pops"}, {30'd0, vc1_pop, vc0_pop}, 32'd0);
    chk({tag, "_push"}, {30'd0, d1_push, d0_push}, 32'd0);
    chk({tag, "_data"}, 32'(d_data), 32'd0);
    chk({tag, "_pause"}, 32'(pause), 32'd0);
    chk({tag, "_cnt0"}, 32'(d0_count), 32'd0);
    chk({tag, "_cnt1"}, 32'(d1_count), 32'd0);
  endtask

  initial begin
    int base;
    int i0;
    int i1;
    int sc;
    logic [DW-1:0] w;

    #1;
    chk_idle_outputs("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Three VC0 words routed by bit 4
    load(0, 6'h05); expect_w(6'h05);
    load(0, 6'h14); expect_w(6'h14);
    load(0, 6'h06); expect_w(6'h06);
    enable = 1'b1;
    wait_pop0(1, 10);
    @(posedge clk); #2;
    chk("t2_pop_2nd", 32'(vc0_pop), 32'd1);
    @(posedge clk); #2;
    chk("t2_pop_3rd", 32'(vc0_pop), 32'd1);
    @(posedge clk); #2;
    chk("t2_pop_stop", 32'(vc0_pop), 32'd0);
    wait_drain(20);
    chk("t2_d0_count", 32'(d0_count), 32'd2);
    chk("t2_d1_count", 32'(d1_count), 32'd1);

    // Async reset mid-cycle drops the in-flight word
    @(negedge clk);
    load(0, 6'h21); expect_w(6'h21);
    load(0, 6'h33); expect_w(6'h33);
    wait_pop0(n_pop0 + 1, 10);
    #1;
    reset = 1'b1;
    clear_model();
    #1;
    chk_idle_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    base = n_push;
    repeat (5) @(negedge clk);
    #1;
    chk("dropped_word", 32'(n_push), 32'(base));

    // Both VCs loaded: starvation limit forces a VC1 slot
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      load(0, 6'(i));
      load(1, 6'(8'h30 + i));
    end
    i0 = 0; i1 = 0; sc = 0;
    while (i0 < 8 || i1 < 8) begin
      if (i0 < 8 && (i1 >= 8 || sc != SL)) begin
        expect_w(6'(i0));
        i0++;
        sc = (i1 < 8) ? sc + 1 : 0;
      end else begin
        expect_w(6'(8'h30 + i1));
        i1++;
        sc = 0;
      end
    end
    wait_drain(100);
    chk("t3_d0_count", 32'(d0_count), 32'(exp_d0));
    chk("t3_d1_count", 32'(d1_count), 32'(exp_d1));

    // Almost-full pauses popping; in-flight words still land
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      w = 6'(i * 7 + 1);
      load(0, w);
      expect_w(w);
    end
    wait_pop0(n_pop0 + 3, 20);
    d1_almost_full = 1'b1;
    @(posedge clk); #2;
    chk("t4_no_pop", 32'(vc0_pop), 32'd0);
    chk("t4_pause", 32'(pause), 32'd1);
    base = n_push;
    repeat (3) begin
      @(posedge clk); #2;
      chk("t4_hold_pop", 32'(vc0_pop), 32'd0);
      chk("t4_hold_pause", 32'(pause), 32'd1);
    end
    chk("t4_inflight", 32'(n_push - base), 32'd2);
    d1_almost_full = 1'b0;
    @(posedge clk); #2;
    chk("t4_resume", 32'(vc0_pop), 32'd1);
    chk("t4_unpause", 32'(pause), 32'd0);
    wait_drain(40);

    // Enable drop with two words in flight
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      w = 6'(i * 11 + 2);
      load(0, w);
      expect_w(w);
    end
    wait_pop0(n_pop0 + 3, 20);
    enable = 1'b0;
    @(posedge clk); #2;
    chk("t5_no_pop", 32'(vc0_pop), 32'd0);
    repeat (6) @(negedge clk);
    #1;
    chk("t5_flushed", 32'(sb.size()), 32'd3);
    chk("t5_vc0_left", 32'(q0.size()), 32'd3);
    chk("t5_d0_count", 32'(d0_count), 32'(exp_d0));
    chk("t5_d1_count", 32'(d1_count), 32'(exp_d1));
    base = n_push;
    repeat (4) @(negedge clk);
    #1;
    chk("t5_cnt_hold0", 32'(d0_count), 32'(exp_d0));
    chk("t5_cnt_hold1", 32'(d1_count), 32'(exp_d1));
    chk("t5_no_push", 32'(n_push), 32'(base));
    chk("t5_pause", 32'(pause), 32'd0);

    // 257 words to D0 wrap the 8-bit counter to 1
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 257; i++) begin
      w = 6'(i) & 6'h2F;
      load(0, w);
      expect_w(w);
    end
    wait_drain(400);
    chk("t6_d0_wrap", 32'(d0_count), 32'd1);
    chk("t6_d1_zero", 32'(d1_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
